// File: rtl/cong_tru_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package cong_tru_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Digit counter width; a single-digit operation still needs a 1-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cong_tru_digit.sv
// Combinational DIGIT-bit ripple-carry slice built from full adders.
module cong_tru_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             ci,
   output logic [DIGIT-1:0] s_d,
   output logic             co,
   output logic             c_msb_in
);

   logic [DIGIT:0] c;

   assign c[0] = ci;

   generate
      for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
         assign s_d[gi]  = a_d[gi] ^ b_d[gi] ^ c[gi];
         assign c[gi+1]  = (a_d[gi] & b_d[gi]) | (c[gi] & (a_d[gi] ^ b_d[gi]));
      end
   endgenerate

   assign co       = c[DIGIT];
   assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/cong_tru_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB first, start/busy/done handshake.
module cong_tru_serial
   import cong_tru_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = cnt_width(N);

   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("cong_tru_serial: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [DIGIT-1:0] s_d;
   logic             co;
   logic             c_msb_in;
   logic [WIDTH-1:0] sum_full;

   cong_tru_digit #(.DIGIT(DIGIT)) u_digit (
      .a_d      (a_sh[DIGIT-1:0]),
      .b_d      (b_sh[DIGIT-1:0]),
      .ci       (carry),
      .s_d      (s_d),
      .co       (co),
      .c_msb_in (c_msb_in)
   );

   // Only the WIDTH-DIGIT bits already produced need storing; the current
   // digit completes the word on the final cycle.
   generate
      if (DIGIT == WIDTH) begin : g_single
         assign sum_full = s_d;
      end else begin : g_multi
         logic [WIDTH-DIGIT-1:0] psum;

         assign sum_full = {s_d, psum};

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               psum <= '0;
            end else if (state == RUN) begin
               psum <= sum_full[WIDTH-1:DIGIT];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         s     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= (mode == MODE_SUB) ? ~b : b;
                  carry <= mode;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               carry <= co;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  s     <= sum_full;
                  cout  <= co;
                  ovf   <= c_msb_in ^ co;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cong_tru_serial.sv
// Scoreboard bench for cong_tru_serial across WIDTH=8 DIGIT=1/2/4/8 and WIDTH=16 DIGIT=16.
module tb_cong_tru_serial;

   typedef struct packed {
      logic [15:0] s;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_v [5];
   logic        mode_v  [5];
   logic [15:0] a_v     [5];
   logic [15:0] b_v     [5];
   logic        busy_v  [5];
   logic        done_v  [5];
   logic        cout_v  [5];
   logic        ovf_v   [5];
   logic [7:0]  s8      [4];
   logic [15:0] s16;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dut8
         cong_tru_serial #(.WIDTH(8), .DIGIT(1 << gi)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_v[gi]),
            .mode  (mode_v[gi]),
            .a     (a_v[gi][7:0]),
            .b     (b_v[gi][7:0]),
            .busy  (busy_v[gi]),
            .done  (done_v[gi]),
            .s     (s8[gi]),
            .cout  (cout_v[gi]),
            .ovf   (ovf_v[gi])
         );
      end
   endgenerate

   cong_tru_serial #(.WIDTH(16), .DIGIT(16)) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_v[4]),
      .mode  (mode_v[4]),
      .a     (a_v[4]),
      .b     (b_v[4]),
      .busy  (busy_v[4]),
      .done  (done_v[4]),
      .s     (s16),
      .cout  (cout_v[4]),
      .ovf   (ovf_v[4])
   );

   function automatic int width_of(input int id);
      return (id == 4) ? 16 : 8;
   endfunction

   function automatic int steps_of(input int id);
      return (id == 4) ? 1 : (8 >> id);
   endfunction

   function automatic logic [15:0] s_of(input int id);
      return (id == 4) ? s16 : {8'h00, s8[id]};
   endfunction

   // Reference: plain integer arithmetic, overflow from operand/result signs.
   function automatic exp_t model(input int w, input logic m, input logic [15:0] a, input logic [15:0] b);
      exp_t        r;
      logic [16:0] mask17;
      logic [15:0] mask, am, bm;
      logic [16:0] sum;
      logic        sa, sbb, ss;
      mask17 = (17'd1 << w) - 17'd1;
      mask   = mask17[15:0];
      am     = a & mask;
      bm     = (m ? ~b : b) & mask;
      sum    = {1'b0, am} + {1'b0, bm} + {16'd0, m};
      r.s    = sum[15:0] & mask;
      r.cout = sum[w];
      sa     = a[w-1];
      sbb    = b[w-1];
      ss     = r.s[w-1];
      r.ovf  = m ? ((sa != sbb) && (ss != sa)) : ((sa == sbb) && (ss != sa));
      return r;
   endfunction

   // Issue one operation, push its expected result, and observe until done.
   task automatic do_op(input int id, input logic m, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int busy_cnt, output exp_t obs);
      @(negedge clk);
      start_v[id] = 1'b1;
      mode_v[id]  = m;
      a_v[id]     = a;
      b_v[id]     = b;
      sb.push_back(model(width_of(id), m, a, b));
      lat      = -1;
      busy_cnt = 0;
      obs      = '0;
      @(negedge clk);
      start_v[id] = 1'b0;
      a_v[id]     = 16'($urandom);
      b_v[id]     = 16'($urandom);
      mode_v[id]  = ~m;
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) @(negedge clk);
         if (busy_v[id]) busy_cnt++;
         if (done_v[id]) begin
            lat      = c - 1;
            obs.s    = s_of(id);
            obs.cout = cout_v[id];
            obs.ovf  = ovf_v[id];
            return;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         start_v[i] = 1'b0;
         mode_v[i]  = 1'b0;
         a_v[i]     = '0;
         b_v[i]     = '0;
      end
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({busy_v[i], done_v[i], cout_v[i], ovf_v[i], s_of(i)} !== 20'h0) begin
            failures++;
            $display("FAIL reset_state id=%0d got busy=%b done=%b cout=%b ovf=%b s=%h exp all 0",
                     i, busy_v[i], done_v[i], cout_v[i], ovf_v[i], s_of(i));
         end
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed(input string name, input int id, input logic m,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] lit_s, input logic lit_c, input logic lit_v);
      int   lat, bc;
      exp_t obs, e;
      do_op(id, m, a, b, lat, bc, obs);
      e = sb.pop_front();
      checks++;
      if (lat != steps_of(id)) begin
         failures++;
         $display("FAIL %s_latency got=%0d exp=%0d", name, lat, steps_of(id));
      end
      checks++;
      if (bc != steps_of(id)) begin
         failures++;
         $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, bc, steps_of(id));
      end
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL %s_scoreboard got s=%h c=%b v=%b exp s=%h c=%b v=%b",
                  name, obs.s, obs.cout, obs.ovf, e.s, e.cout, e.ovf);
      end
      checks++;
      if ({obs.s, obs.cout, obs.ovf} !== {lit_s, lit_c, lit_v}) begin
         failures++;
         $display("FAIL %s_value got s=%h c=%b v=%b exp s=%h c=%b v=%b",
                  name, obs.s, obs.cout, obs.ovf, lit_s, lit_c, lit_v);
      end
      $display("op %s id=%0d mode=%0b a=%h b=%h -> s=%h cout=%b ovf=%b lat=%0d",
               name, id, m, a, b, obs.s, obs.cout, obs.ovf, lat);
   endtask

   task automatic test_handshake();
      logic [15:0] old_s;
      int          lat;
      bit          held;
      exp_t        e, obs;
      // First op with a mid-run start pulse carrying different operands.
      old_s = s_of(0);
      @(negedge clk);
      start_v[0] = 1'b1; mode_v[0] = 1'b0; a_v[0] = 16'h12; b_v[0] = 16'h34;
      sb.push_back(model(8, 1'b0, 16'h12, 16'h34));
      @(negedge clk);
      start_v[0] = 1'b0;
      lat = -1; held = 1'b1; obs = '0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 3) begin
            start_v[0] = 1'b1; mode_v[0] = 1'b1; a_v[0] = 16'hFF; b_v[0] = 16'h0F;
         end
         if (c == 4) start_v[0] = 1'b0;
         if (done_v[0]) begin
            lat = c - 1;
            obs.s = s_of(0); obs.cout = cout_v[0]; obs.ovf = ovf_v[0];
            break;
         end
         if (s_of(0) !== old_s) held = 1'b0;
         @(negedge clk);
      end
      e = sb.pop_front();
      checks++;
      if (lat != 8) begin
         failures++;
         $display("FAIL hs_ignored_start_latency got=%0d exp=8", lat);
      end
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL hs_ignored_start_result got s=%h c=%b v=%b exp s=%h c=%b v=%b",
                  obs.s, obs.cout, obs.ovf, e.s, e.cout, e.ovf);
      end
      checks++;
      if (!held) begin
         failures++;
         $display("FAIL hs_hold_during_run1 got=changed exp=held s=%h", old_s);
      end
      $display("op hs1 a=12 b=34 -> s=%h lat=%0d", obs.s, lat);
      // Second op issued during the done cycle: back-to-back acceptance.
      old_s = obs.s;
      start_v[0] = 1'b1; mode_v[0] = 1'b1; a_v[0] = 16'h30; b_v[0] = 16'h05;
      sb.push_back(model(8, 1'b1, 16'h30, 16'h05));
      @(negedge clk);
      start_v[0] = 1'b0;
      checks++;
      if (busy_v[0] !== 1'b1) begin
         failures++;
         $display("FAIL hs_back_to_back_accept got busy=%b exp=1", busy_v[0]);
      end
      lat = -1; held = 1'b1; obs = '0;
      for (int c = 1; c <= 40; c++) begin
         if (done_v[0]) begin
            lat = c - 1;
            obs.s = s_of(0); obs.cout = cout_v[0]; obs.ovf = ovf_v[0];
            break;
         end
         if (s_of(0) !== old_s) held = 1'b0;
         @(negedge clk);
      end
      e = sb.pop_front();
      checks++;
      if (lat != 8) begin
         failures++;
         $display("FAIL hs_back_to_back_latency got=%0d exp=8", lat);
      end
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL hs_back_to_back_result got s=%h c=%b v=%b exp s=%h c=%b v=%b",
                  obs.s, obs.cout, obs.ovf, e.s, e.cout, e.ovf);
      end
      checks++;
      if (!held) begin
         failures++;
         $display("FAIL hs_hold_during_run2 got=changed exp=held s=%h", old_s);
      end
      $display("op hs2 a=30 b=05 sub -> s=%h lat=%0d", obs.s, lat);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start_v[0] = 1'b1; mode_v[0] = 1'b0; a_v[0] = 16'h55; b_v[0] = 16'h11;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy_v[0], done_v[0], cout_v[0], ovf_v[0], s_of(0)} !== 20'h0) begin
         failures++;
         $display("FAIL reset_mid_run got busy=%b done=%b cout=%b ovf=%b s=%h exp all 0",
                  busy_v[0], done_v[0], cout_v[0], ovf_v[0], s_of(0));
      end
      @(negedge clk);
      rst_n = 1'b1;
      $display("op reset_mid id=0 aborted at run cycle 3");
      test_directed("after_reset", 0, 1'b0, 16'h22, 16'h14, 16'h36, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      int          lat, bc;
      exp_t        obs, e;
      logic        m;
      logic [15:0] a, b;
      for (int id = 0; id < 5; id++) begin
         for (int n = 0; n < 12; n++) begin
            m = 1'($urandom_range(1, 0));
            a = 16'($urandom);
            b = 16'($urandom);
            do_op(id, m, a, b, lat, bc, obs);
            e = sb.pop_front();
            checks++;
            if (lat != steps_of(id)) begin
               failures++;
               $display("FAIL rand_latency id=%0d got=%0d exp=%0d", id, lat, steps_of(id));
            end
            checks++;
            if (obs !== e) begin
               failures++;
               $display("FAIL rand_result id=%0d mode=%b a=%h b=%h got s=%h c=%b v=%b exp s=%h c=%b v=%b",
                        id, m, a, b, obs.s, obs.cout, obs.ovf, e.s, e.cout, e.ovf);
            end
            $display("op rand id=%0d mode=%0b a=%h b=%h -> s=%h cout=%b ovf=%b",
                     id, m, a, b, obs.s, obs.cout, obs.ovf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed("add_0a_05", 0, 1'b0, 16'h0A, 16'h05, 16'h0F, 1'b0, 1'b0);
      test_directed("add_f7_91", 0, 1'b0, 16'hF7, 16'h91, 16'h88, 1'b1, 1'b0);
      test_directed("add_7f_01", 0, 1'b0, 16'h7F, 16'h01, 16'h80, 1'b0, 1'b1);
      test_directed("sub_05_0a", 2, 1'b1, 16'h05, 16'h0A, 16'hFB, 1'b0, 1'b0);
      test_directed("sub_80_01", 2, 1'b1, 16'h80, 16'h01, 16'h7F, 1'b1, 1'b1);
      test_handshake();
      test_reset_mid();
      test_directed("add16_ffff_1", 4, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
